fa_exhaustive_checker: RTL and testbench
========================================

# fa_exhaustive_checker

Hardware stimulus-and-check engine for the 1-bit full adder. It drives all eight {A,B,Cin} combinations into an external full-adder instance and samples that instance's sum/cout. Each sample is compared against the internally computed golden result, and the engine reports pass/fail, the error count and the first failing vector. It sits on the driving side of the full adder's A/B/Cin → sum/cout interface and is used as an on-chip BIST wrapper and as a synthesizable self-checking bench.

## Interface
Parameters:
- SETTLE_CYCLES, default 2: number of extra cycles each vector is held before the adder outputs are sampled. Legal range 0–15.

Ports:
- clk  input  1  rising-edge clock; all state updates on this edge.
- rst  input  1  synchronous, active-high reset. Takes effect on the next rising clk edge.
- start  input  1  level-sampled request to begin a run. Accepted in IDLE or DONE; ignored while busy.
- dut_sum  input  1  sum output of the adder under test.
- dut_cout  input  1  carry output of the adder under test.
- A, B, Cin  output  1 each  registered stimulus to the adder under test.
- busy  output  1  high while a run is in progress (RUN state).
- done  output  1  high in DONE state; held until start or rst.
- pass  output  1  valid when done=1; high iff err_count==0. Otherwise 0.
- err_count  output  4  number of mismatching vectors in the current or last run, 0–8.
- first_fail_valid  output  1  high once any mismatch has been recorded in the current run.
- first_fail_vec  output  3  {A,B,Cin} of the first mismatching vector. Holds 3'b000 until first_fail_valid is high.

## Operation
- State machine: IDLE, RUN, DONE.
- Internal registers:
  - vec: 3-bit vector index.
  - hold: 4-bit hold counter.
  - {A,B,Cin} is driven directly from vec; vec order is 000, 001, …, 111 with A as MSB.
- IDLE → RUN on start=1:
  - vec←0, hold←0.
  - err_count←0, first_fail_valid←0, first_fail_vec←0, done←0, pass←0.
- RUN:
  - When hold<SETTLE_CYCLES: hold increments.
  - When hold==SETTLE_CYCLES (sample edge):
    - Compare dut_sum against A^B^Cin.
    - Compare dut_cout against (A&B)|(A&Cin)|(B&Cin).
    - On any mismatch: err_count increments. If first_fail_valid==0, capture vec into first_fail_vec and set first_fail_valid.
    - hold←0.
    - If vec==7: go to DONE. Otherwise vec←vec+1 and stay in RUN.
- DONE:
  - done=1, pass=(err_count==0).
  - A/B/Cin hold 3'b111.
  - start=1 begins a new run exactly as from IDLE, clearing all results.
- A mismatch on sum alone, cout alone, or both counts as one error for that vector.
- err_count cannot exceed 8, so the counter needs no saturation logic.
- start held high continuously: after a run completes, the next run begins on the first edge in DONE.

## Timing
- Reset values, after the first rising edge with rst=1:
  - State IDLE, vec=0, hold=0.
  - A=B=Cin=0, busy=0, done=0, pass=0, err_count=0, first_fail_valid=0, first_fail_vec=0.
- rst has priority over start and over all RUN activity.
- Reset mid-run aborts the run: all outputs take their reset values on that edge, and no partial result is retained.
- start accepted on edge E0: busy=1 and vector 000 appear after E0.
- Each vector is driven for SETTLE_CYCLES+1 cycles. It is sampled on the edge E0+(k+1)(SETTLE_CYCLES+1), for k = 0..7.
- Stimulus for vector k+1 changes on the same edge that samples vector k. err_count and first_fail_* update on that edge.
- done=1 and busy=0 after edge E0+8(SETTLE_CYCLES+1). With the default this is E0+24; with SETTLE_CYCLES=0 it is E0+8.
- The adder under test is combinational, so a correct adder meets any SETTLE_CYCLES ≥ 0.

## Test plan
- Correct adder connected, SETTLE_CYCLES=2, one start pulse → done rises 24 cycles after start, pass=1, err_count=0, first_fail_valid=0, A/B/Cin=111.
- dut_cout tied 0 → err_count=4, first_fail_vec=3'b011, first_fail_valid=1, pass=0.
- dut_sum inverted (correct cout) → err_count=8, first_fail_vec=3'b000, pass=0.
- start pulsed again at cycle 5 of a run → ignored; completion still at cycle 24 with the unchanged result. start in DONE restarts and clears err_count to 0 on the accept edge.
- rst asserted at cycle 10 of a run → next edge shows all reset values and IDLE. A subsequent start produces a clean full run (pass=1 with a correct adder).
- SETTLE_CYCLES=0 with a correct adder → the vector changes every cycle, done is high 8 cycles after start, pass=1.

Source files
------------

// File: rtl/fa_exhaustive_checker.sv
// Exhaustive BIST engine for a 1-bit full adder: walks all eight {A,B,Cin}
// vectors, samples the external adder and reports pass/fail and first failure.
module fa_exhaustive_checker #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dut_sum,
  input  logic       dut_cout,
  output logic       A,
  output logic       B,
  output logic       Cin,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic       first_fail_valid,
  output logic [2:0] first_fail_vec,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

  state_t     r_state, w_state_n;
  logic [2:0] r_vec, w_vec_n;
  logic [3:0] r_hold, w_hold_n;
  logic [3:0] r_err, w_err_n;
  logic       r_ffv, w_ffv_n;
  logic [2:0] r_ffvec, w_ffvec_n;

  logic w_gold_sum, w_gold_cout, w_mismatch, w_sample;

  // Handshake: start is a level request, accepted on any edge where the
  // engine is IDLE or DONE; while busy it is ignored (no back-pressure signal).
  assign w_gold_sum  = r_vec[2] ^ r_vec[1] ^ r_vec[0];
  assign w_gold_cout = (r_vec[2] & r_vec[1]) | (r_vec[2] & r_vec[0]) | (r_vec[1] & r_vec[0]);
  assign w_mismatch  = (dut_sum != w_gold_sum) || (dut_cout != w_gold_cout);
  assign w_sample    = (r_hold == SETTLE);

  always_comb begin
    w_state_n = r_state;
    w_vec_n   = r_vec;
    w_hold_n  = r_hold;
    w_err_n   = r_err;
    w_ffv_n   = r_ffv;
    w_ffvec_n = r_ffvec;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_n = S_RUN;
          w_vec_n   = 3'd0;
          w_hold_n  = 4'd0;
          w_err_n   = 4'd0;
          w_ffv_n   = 1'b0;
          w_ffvec_n = 3'd0;
        end
      end
      S_RUN: begin
        if (!w_sample) begin
          w_hold_n = r_hold + 4'd1;
        end else begin
          w_hold_n = 4'd0;
          if (w_mismatch) begin
            w_err_n = r_err + 4'd1;
            if (!r_ffv) begin
              w_ffv_n   = 1'b1;
              w_ffvec_n = r_vec;
            end
          end
          // The last vector stays on the pins so DONE shows 3'b111.
          if (r_vec == 3'd7) w_state_n = S_DONE;
          else               w_vec_n   = r_vec + 3'd1;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_vec   <= 3'd0;
      r_hold  <= 4'd0;
      r_err   <= 4'd0;
      r_ffv   <= 1'b0;
      r_ffvec <= 3'd0;
    end else begin
      r_state <= w_state_n;
      r_vec   <= w_vec_n;
      r_hold  <= w_hold_n;
      r_err   <= w_err_n;
      r_ffv   <= w_ffv_n;
      r_ffvec <= w_ffvec_n;
    end
  end

  assign {A, B, Cin}      = r_vec;
  assign busy             = (r_state == S_RUN);
  assign done             = (r_state == S_DONE);
  assign pass             = done && (r_err == 4'd0);
  assign err_count        = r_err;
  assign first_fail_valid = r_ffv;
  assign first_fail_vec   = r_ffvec;
  assign dbg_state        = r_state;

endmodule

// File: tb/tb_fa_exhaustive_checker.sv
// Bench for fa_exhaustive_checker: two instances (SETTLE 2 and 0) driving a
// fault-injectable full adder, checked every cycle against a timing model.
module tb_fa_exhaustive_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [7:0] sum_flip = 8'd0;
  logic [7:0] cout_flip = 8'd0;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Instance 2: SETTLE_CYCLES = 2
  logic a2, b2, c2, sum2, cout2, busy2, done2, pass2, ffv2;
  logic [3:0] err2;
  logic [2:0] ffvec2, v2;
  logic [1:0] dbg2, tot2;
  assign v2    = {a2, b2, c2};
  assign tot2  = {1'b0, a2} + {1'b0, b2} + {1'b0, c2};
  assign sum2  = tot2[0] ^ sum_flip[v2];
  assign cout2 = tot2[1] ^ cout_flip[v2];

  fa_exhaustive_checker #(.SETTLE_CYCLES(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .dut_sum(sum2), .dut_cout(cout2),
    .A(a2), .B(b2), .Cin(c2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .first_fail_valid(ffv2), .first_fail_vec(ffvec2),
    .dbg_state(dbg2)
  );

  // Instance 0: SETTLE_CYCLES = 0
  logic a0, b0, c0, sum0, cout0, busy0, done0, pass0, ffv0;
  logic [3:0] err0;
  logic [2:0] ffvec0, v0;
  logic [1:0] dbg0, tot0;
  assign v0    = {a0, b0, c0};
  assign tot0  = {1'b0, a0} + {1'b0, b0} + {1'b0, c0};
  assign sum0  = tot0[0] ^ sum_flip[v0];
  assign cout0 = tot0[1] ^ cout_flip[v0];

  fa_exhaustive_checker #(.SETTLE_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .dut_sum(sum0), .dut_cout(cout0),
    .A(a0), .B(b0), .Cin(c0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .first_fail_valid(ffv0), .first_fail_vec(ffvec0),
    .dbg_state(dbg0)
  );

  // ---------------- reference model ----------------
  // Per instance: has a run ever been accepted since reset, and how many
  // edges have passed since the accept edge. Everything else follows.
  int         per [2] = '{3, 1};
  bit         m_on [2] = '{1'b0, 1'b0};
  int         m_t [2] = '{0, 0};
  logic [7:0] m_sf [2];
  logic [7:0] m_cf [2];
  bit         m_ready = 1'b0;

  function automatic bit vec_faulty(input int v, input logic [7:0] sf, input logic [7:0] cf);
    int a, b, c, s, co;
    a  = (v >> 2) & 1;
    b  = (v >> 1) & 1;
    c  = v & 1;
    s  = ((a + b + c) % 2) ^ int'(sf[v]);
    co = ((a + b + c) / 2) ^ int'(cf[v]);
    return (s != (a + b + c) % 2) || (co != (a + b + c) / 2);
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_on[k] = 1'b0;
        m_t[k]  = 0;
      end else if (start && (!m_on[k] || m_t[k] >= 8 * per[k])) begin
        m_on[k] = 1'b1;
        m_t[k]  = 0;
        m_sf[k] = sum_flip;
        m_cf[k] = cout_flip;
      end else if (m_on[k] && m_t[k] < 8 * per[k]) begin
        m_t[k] = m_t[k] + 1;
      end
    end
    if (rst) m_ready = 1'b1;
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_inst(input int k, input logic [2:0] vec, input logic bz,
                            input logic dn, input logic ps, input logic [3:0] ec,
                            input logic fv, input logic [2:0] fvec, input logic [1:0] st);
    int n, errs, first, e_vec, e_busy, e_done, e_st;
    string p;
    p = $sformatf("s%0d", per[k] - 1);
    if (!m_on[k]) begin
      n = 0; errs = 0; first = -1; e_vec = 0; e_busy = 0; e_done = 0; e_st = 0;
    end else begin
      n = m_t[k] / per[k];
      if (n > 8) n = 8;
      e_vec  = (n < 8) ? n : 7;
      e_busy = (n < 8) ? 1 : 0;
      e_done = 1 - e_busy;
      e_st   = e_busy ? 1 : 2;
      errs = 0; first = -1;
      for (int v = 0; v < n; v++) begin
        if (vec_faulty(v, m_sf[k], m_cf[k])) begin
          errs++;
          if (first < 0) first = v;
        end
      end
    end
    chk({p, "_vec"}, int'(vec), e_vec);
    chk({p, "_busy"}, int'(bz), e_busy);
    chk({p, "_done"}, int'(dn), e_done);
    chk({p, "_pass"}, int'(ps), (e_done == 1 && errs == 0) ? 1 : 0);
    chk({p, "_err_count"}, int'(ec), errs);
    chk({p, "_ff_valid"}, int'(fv), (first >= 0) ? 1 : 0);
    chk({p, "_ff_vec"}, int'(fvec), (first >= 0) ? first : 0);
    chk({p, "_state"}, int'(st), e_st);
  endtask

  always @(negedge clk) begin
    if (m_ready) begin
      check_inst(0, v2, busy2, done2, pass2, err2, ffv2, ffvec2, dbg2);
      check_inst(1, v0, busy0, done0, pass0, err0, ffv0, ffvec0, dbg0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Returns the cycle (counted from the current edge) on which done first
  // shows for each instance; -1 if the budget expires.
  task automatic wait_done(input int limit, output int cyc2, output int cyc0);
    cyc2 = -1;
    cyc0 = -1;
    for (int i = 1; i <= limit; i++) begin
      @(posedge clk); #1;
      if (cyc0 < 0 && done0) cyc0 = i;
      if (done2) begin
        cyc2 = i;
        break;
      end
    end
    if (cyc2 < 0) chk("wait_done_timeout", 0, 1);
  endtask

  task automatic wait_idle(input int limit);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk); #1;
      if (!busy2 && !busy0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("wait_idle_timeout", 0, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c2_cyc, c0_cyc;

    // clock/reset
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_abc", int'({a2, b2, c2}), 0);
    chk("reset_busy_done", int'({busy2, done2, pass2}), 0);
    chk("reset_err", int'(err2), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // correct adder, default settle
    sum_flip = 8'h00; cout_flip = 8'h00;
    pulse_start();
    wait_done(60, c2_cyc, c0_cyc);
    chk("good_done_cycle_s2", c2_cyc, 24);
    chk("good_done_cycle_s0", c0_cyc, 8);
    chk("good_pass", int'(pass2), 1);
    chk("good_err", int'(err2), 0);
    chk("good_ffv", int'(ffv2), 0);
    chk("good_abc", int'({a2, b2, c2}), 7);
    chk("good_pass_s0", int'(pass0), 1);

    // cout stuck at 0: fails on 011, 101, 110, 111
    cout_flip = 8'b1110_1000;
    pulse_start();
    wait_done(60, c2_cyc, c0_cyc);
    chk("cout0_err", int'(err2), 4);
    chk("cout0_ffvec", int'(ffvec2), 3);
    chk("cout0_ffv", int'(ffv2), 1);
    chk("cout0_pass", int'(pass2), 0);

    // sum inverted, cout correct: every vector fails
    cout_flip = 8'h00; sum_flip = 8'hff;
    pulse_start();
    wait_done(60, c2_cyc, c0_cyc);
    chk("suminv_err", int'(err2), 8);
    chk("suminv_ffvec", int'(ffvec2), 0);
    chk("suminv_pass", int'(pass2), 0);

    // restart from DONE clears results; a start mid-run is ignored
    sum_flip = 8'h00; cout_flip = 8'b1110_1000;
    pulse_start();
    chk("restart_err_cleared", int'(err2), 0);
    chk("restart_busy", int'(busy2), 1);
    repeat (4) begin @(posedge clk); #1; end
    pulse_start();
    wait_done(60, c2_cyc, c0_cyc);
    chk("midstart_done_cycle", c2_cyc, 19);
    chk("midstart_err", int'(err2), 4);

    // reset at cycle 10 of a run, then a clean run
    pulse_start();
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_state", int'(dbg2), 0);
    chk("midrst_outs", int'({busy2, done2, pass2, ffv2}), 0);
    chk("midrst_err", int'(err2), 0);
    chk("midrst_abc", int'({a2, b2, c2}), 0);
    sum_flip = 8'h00; cout_flip = 8'h00;
    pulse_start();
    wait_done(60, c2_cyc, c0_cyc);
    chk("post_rst_pass", int'(pass2), 1);

    // randomized: random adder faults, start pulses and occasional resets
    for (int it = 0; it < 25; it++) begin
      start = 1'b0;
      rst = 1'b0;
      wait_idle(200);
      if ($urandom_range(0, 3) == 0) begin
        sum_flip = 8'h00; cout_flip = 8'h00;
      end else begin
        sum_flip  = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
        cout_flip = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
      end
      for (int c = 0; c < 60; c++) begin
        start = ($urandom_range(0, 7) == 0);
        rst   = ($urandom_range(0, 59) == 0);
        @(posedge clk); #1;
      end
    end
    start = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
